traffic_light_monitor: RTL
==========================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter GREEN_CYC, default 7, samples a green/red phase lasts.
REQ-002 SHALL have parameter YELLOW_CYC, default 2, samples a yellow/red phase lasts.
REQ-003 SHALL have parameter ALLRED_CYC, default 2, samples each all-red phase lasts.
REQ-004 SHALL have port clk  input  1  clock; all sampling on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port light_A  input  3  road A lamp: bit0 green, bit1 yellow, bit2 red.
REQ-007 SHALL have port light_B  input  3  road B lamp, same encoding.
REQ-008 SHALL have port clear  input  1  synchronous fault clear, one-cycle pulse.
REQ-009 SHALL have port fault  output  1  sticky fault flag.
REQ-010 SHALL have port fault_code  output  3  0 none, 1 ENCODING, 2 CONFLICT, 3 SEQUENCE, 4 TIMING.
REQ-011 SHALL have port fault_phase  output  3  monitor phase index when the fault was detected.
REQ-012 SHALL have port locked  output  1  high while tracking phases G_A..R_2.
REQ-013 SHALL have port cycle_cnt  output  8  count of completed full cycles, wraps 255->0.

Function
REQ-014 SHALL sample both lamps every clk; every output registered, responding one cycle after the offending sample.
REQ-015 SHALL use FSM states SYNC, G_A(A=001,B=100), Y_A(010,100), R_1(100,100), G_B(100,001), Y_B(100,010), R_2(100,100), FAULT; phase index 0..5 = G_A..R_2, 6 = SYNC.
REQ-016 SHALL keep a dwell counter counting consecutive samples of the current pattern, reloaded to 1 on each legal transition.
REQ-017 SHALL, in SYNC, enter G_A on the first sample of A=001,B=100; the first dwell is checked only against the upper bound.
REQ-018 SHALL, in tracking states, accept a change only to the next state in the order G_A->Y_A->R_1->G_B->Y_B->R_2->G_A.
REQ-019 SHALL flag TIMING when the pattern persists past the phase length, at sample N+1, or changes with dwell < N (N = GREEN_CYC, YELLOW_CYC or ALLRED_CYC).
REQ-020 SHALL flag ENCODING when either lamp is not one-hot, in any state except FAULT.
REQ-021 SHALL flag CONFLICT when both lamps are one-hot and neither is red.
REQ-022 SHALL flag SEQUENCE for any other one-hot, non-conflicting pattern that is not the current or next expected pattern.
REQ-023 SHALL resolve simultaneous faults by priority ENCODING > CONFLICT > SEQUENCE > TIMING.
REQ-024 SHALL, on any fault, set fault=1, latch fault_code and fault_phase, drop locked, enter FAULT, and freeze cycle_cnt.
REQ-025 SHALL hold in FAULT, ignoring lamps, until clear; clear returns the FSM to SYNC and zeroes fault, fault_code and fault_phase.
REQ-026 SHALL give clear priority over detection in the same cycle; that cycle's sample is discarded.
REQ-027 SHALL ignore clear outside FAULT.
REQ-028 SHALL increment cycle_cnt on each legal R_2->G_A transition.

Reset
REQ-029 SHALL on reset force state SYNC, dwell 0, fault 0, fault_code 0, fault_phase 0, locked 0, cycle_cnt 0.
REQ-030 SHALL apply reset mid-phase or mid-fault immediately, with no pending fault surviving reset.

Structure
REQ-031 SHALL place lamp encodings (GREEN, YELLOW, RED), fault codes, phase indices and default phase lengths in shared package traffic_pkg.
REQ-032 SHALL use one sub-module tl_dwell_counter: load, increment, equal-N and greater-than-N compare outputs, 4-bit wide.

Verification
REQ-033 SHALL cover: reset released, legal sequence with default lengths (7/2/2/7/2/2) for 3 cycles -> fault=0, locked=1 from the second sample, cycle_cnt=3.
REQ-034 SHALL cover: G_A held 8 samples -> fault=1, fault_code=4, fault_phase=0.
REQ-035 SHALL cover: in Y_A, drive A=001,B=001 -> fault_code=2; on a later sample drive A=011 -> no change, still code 2.
REQ-036 SHALL cover: G_A jumps straight to R_1 pattern after 7 samples -> fault_code=3, fault_phase=0.
REQ-037 SHALL cover: fault then clear pulse while light_A=000 -> fault=0, state SYNC, no ENCODING; next sample A=000 -> fault_code=1.
REQ-038 SHALL cover: reset asserted during G_B dwell 3 -> all outputs 0 on the next clk edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp encodings, fault codes, phase indices and phase helpers
package traffic_pkg;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  localparam int DEF_GREEN_CYC  = 7;
  localparam int DEF_YELLOW_CYC = 2;
  localparam int DEF_ALLRED_CYC = 2;

  localparam logic [2:0] PH_G_A  = 3'd0;
  localparam logic [2:0] PH_Y_A  = 3'd1;
  localparam logic [2:0] PH_R_1  = 3'd2;
  localparam logic [2:0] PH_G_B  = 3'd3;
  localparam logic [2:0] PH_Y_B  = 3'd4;
  localparam logic [2:0] PH_R_2  = 3'd5;
  localparam logic [2:0] PH_SYNC = 3'd6;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_ENCODING = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_SEQUENCE = 3'd3,
    FC_TIMING   = 3'd4
  } fault_code_e;

  typedef enum logic [2:0] {
    ST_SYNC, ST_G_A, ST_Y_A, ST_R_1, ST_G_B, ST_Y_B, ST_R_2, ST_FAULT
  } state_e;

  // Expected {light_A, light_B} for each tracking state.
  function automatic logic [5:0] phase_lamps(input state_e s);
    case (s)
      ST_G_A:  return {GREEN, RED};
      ST_Y_A:  return {YELLOW, RED};
      ST_G_B:  return {RED, GREEN};
      ST_Y_B:  return {RED, YELLOW};
      default: return {RED, RED};
    endcase
  endfunction

  function automatic state_e next_phase(input state_e s);
    case (s)
      ST_G_A:  return ST_Y_A;
      ST_Y_A:  return ST_R_1;
      ST_R_1:  return ST_G_B;
      ST_G_B:  return ST_Y_B;
      ST_Y_B:  return ST_R_2;
      default: return ST_G_A;
    endcase
  endfunction

  function automatic logic [2:0] phase_index(input state_e s);
    case (s)
      ST_G_A:  return PH_G_A;
      ST_Y_A:  return PH_Y_A;
      ST_R_1:  return PH_R_1;
      ST_G_B:  return PH_G_B;
      ST_Y_B:  return PH_Y_B;
      ST_R_2:  return PH_R_2;
      default: return PH_SYNC;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == GREEN) || (v == YELLOW) || (v == RED);
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// rtl/tl_dwell_counter.sv - 4-bit saturating dwell counter with equal/greater-than-N compares
module tl_dwell_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  input  logic [3:0] n_i,
  output logic [3:0] count_o,
  output logic       eq_o,
  output logic       gt_o
);

  logic [3:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (inc_i && (count_q != 4'hF)) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign count_o = count_q;
  assign eq_o    = (count_q == n_i);
  assign gt_o    = (count_q > n_i);

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - two-road traffic light sequence/timing monitor with sticky fault report
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_A,
  input  logic [2:0] light_B,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] fault_phase,
  output logic       locked,
  output logic [7:0] cycle_cnt
);

  localparam logic [3:0] GREEN_N  = 4'(GREEN_CYC);
  localparam logic [3:0] YELLOW_N = 4'(YELLOW_CYC);
  localparam logic [3:0] ALLRED_N = 4'(ALLRED_CYC);

  state_e      state_q, state_d;
  logic        fault_q, fault_d;
  logic [2:0]  code_q, code_d;
  logic [2:0]  phase_q, phase_d;
  logic        locked_q, locked_d;
  logic [7:0]  cyc_q, cyc_d;
  logic        first_q, first_d;
  fault_code_e det;

  logic        dw_load, dw_inc, dw_eq, dw_gt;
  logic [3:0]  dw_load_val, dw_n, dw_count;
  logic [5:0]  lamps;

  tl_dwell_counter u_dwell (
    .clk        (clk),
    .reset      (reset),
    .load_i     (dw_load),
    .load_val_i (dw_load_val),
    .inc_i      (dw_inc),
    .n_i        (dw_n),
    .count_o    (dw_count),
    .eq_o       (dw_eq),
    .gt_o       (dw_gt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_SYNC;
      fault_q  <= 1'b0;
      code_q   <= 3'd0;
      phase_q  <= 3'd0;
      locked_q <= 1'b0;
      cyc_q    <= 8'd0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      phase_q  <= phase_d;
      locked_q <= locked_d;
      cyc_q    <= cyc_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_G_A, ST_G_B: dw_n = GREEN_N;
      ST_Y_A, ST_Y_B: dw_n = YELLOW_N;
      ST_R_1, ST_R_2: dw_n = ALLRED_N;
      default:        dw_n = 4'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    code_d      = code_q;
    phase_d     = phase_q;
    cyc_d       = cyc_q;
    first_d     = first_q;
    dw_load     = 1'b0;
    dw_load_val = 4'd0;
    dw_inc      = 1'b0;
    det         = FC_NONE;
    lamps       = {light_A, light_B};

    if (state_q == ST_FAULT) begin
      if (clear) begin
        state_d = ST_SYNC;
        fault_d = 1'b0;
        code_d  = 3'd0;
        phase_d = 3'd0;
      end
    end else begin
      if (!is_onehot(light_A) || !is_onehot(light_B)) begin
        det = FC_ENCODING;
      end else if ((light_A != RED) && (light_B != RED)) begin
        det = FC_CONFLICT;
      end else if (state_q == ST_SYNC) begin
        if (lamps == phase_lamps(ST_G_A)) begin
          state_d     = ST_G_A;
          dw_load     = 1'b1;
          dw_load_val = 4'd1;
          first_d     = 1'b1;
        end
      end else if (lamps == phase_lamps(state_q)) begin
        if (dw_eq || dw_gt) det = FC_TIMING;
        else                dw_inc = 1'b1;
      end else if (lamps == phase_lamps(next_phase(state_q))) begin
        // The phase entered from SYNC was caught mid-way, so only its upper bound is meaningful.
        if (!first_q && !dw_eq && !dw_gt) begin
          det = FC_TIMING;
        end else begin
          state_d     = next_phase(state_q);
          dw_load     = 1'b1;
          dw_load_val = 4'd1;
          first_d     = 1'b0;
          if (state_q == ST_R_2) cyc_d = cyc_q + 8'd1;
        end
      end else begin
        det = FC_SEQUENCE;
      end

      if (det != FC_NONE) begin
        state_d     = ST_FAULT;
        fault_d     = 1'b1;
        code_d      = det;
        phase_d     = phase_index(state_q);
        dw_load     = 1'b1;
        dw_load_val = 4'd0;
        first_d     = 1'b0;
      end
    end

    locked_d = (state_d != ST_SYNC) && (state_d != ST_FAULT);
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_phase = phase_q;
  assign locked      = locked_q;
  assign cycle_cnt   = cyc_q;

endmodule
